pet_stats_engine: RTL
=====================

# pet_stats_engine

Pet state engine that owns the five status levels (hambre, diversion, energia, felicidad, vida) shown on the multiplexed 7-segment display. It decays levels on a prescaled time tick, applies debounced user-button actions, and tracks awake/sleep/dead mode. It sits directly upstream of display7SEG: its five 4-bit outputs drive digit_0..digit_4 unchanged. All levels are BCD-safe, in the range 0..9, with 9 the best value.

## Interface
- TICK_DIV, 50_000_000: clock cycles per game tick (1 s at 50 MHz).
- HUNGER_TICKS, 4: ticks per hambre decay step.
- FUN_TICKS, 3: ticks per diversion decay step.
- ENERGY_TICKS, 5: ticks per energia step (decay awake, recovery asleep).
- LIFE_TICKS, 2: ticks per vida evaluation.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- btn_feed  in  1  one-cycle pulse, already debounced.
- btn_play  in  1  one-cycle pulse, already debounced.
- btn_sleep  in  1  one-cycle pulse, already debounced.
- hambre  out  4  satiety level 0..9, drives digit_0.
- diversion  out  4  fun level 0..9, drives digit_1.
- energia  out  4  energy level 0..9, drives digit_2.
- felicidad  out  4  happiness level 0..9, drives digit_3.
- vida  out  4  health level 0..9, drives digit_4.
- sleeping  out  1  high in SLEEP.
- dead  out  1  high in DEAD.
- tick  out  1  one-cycle game-tick strobe.

## Operation
- Reset values: hambre, diversion, energia, felicidad and vida all = 9. sleeping = 0, dead = 0, tick = 0. All period counters = 0. State = AWAKE.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick is high on the cycle the count equals TICK_DIV-1.
- Per-stat period counters advance only on tick. Each wraps at PERIOD-1 and raises a one-cycle step event on that wrap.
- State machine:
  - AWAKE→SLEEP on btn_sleep.
  - SLEEP→AWAKE on btn_sleep, or automatically when energia is 9 at a tick.
  - Any state→DEAD when vida becomes 0.
  - DEAD is left only by reset.
- Actions are applied only in AWAKE. Only one action is taken per cycle, with priority btn_sleep > btn_feed > btn_play.
  - feed: hambre +3.
  - play: diversion +2, energia −1.
- In SLEEP, btn_feed and btn_play are ignored.
- Decay rules:
  - hambre step event: −1 in AWAKE and SLEEP.
  - diversion step event: −1 in AWAKE only.
  - energia step event: −1 in AWAKE, +1 in SLEEP.
- Combining rule: new value = saturate_0..9(current + action delta − decay delta). Use 5-bit signed-safe intermediates. Never wrap.
- vida step event, evaluated on the current registered values:
  - if hambre==0 or energia==0: vida −1.
  - else if hambre≥5 and energia≥5: vida +1, saturating at 9.
  - else: hold.
- felicidad is recomputed every cycle as (hambre + diversion) >> 1 from the registered values.
- In DEAD:
  - hambre, diversion, energia and vida are frozen.
  - felicidad is forced to 0.
  - The prescaler keeps running; tick still pulses.
  - All buttons are ignored.

## Timing
- All outputs are registered.
- A button sampled high at edge N is reflected on the outputs after edge N.
- A step event at edge N updates its stat at edge N, visible in cycle N+1.
- felicidad lags hambre and diversion by one cycle.
- dead and sleeping change on the same edge as the state register.
- A vida change to 0 asserts dead on that edge. Stats freeze from the next edge.
- Reset asserted mid-operation returns every register to its reset value on the next edge, regardless of state or pending events.
- A button pulse coincident with reset is discarded.

## Test plan
- Decay: TICK_DIV=4, HUNGER_TICKS=4, no buttons after reset release → tick every 4 cycles; hambre 9→8 exactly 16 cycles after release; diversion 9→8 after 12 cycles.
- Saturation and feed: drive hambre down to 7, then pulse btn_feed → hambre 9, not 10. In another run, pulse btn_play at energia 0 → energia stays 0, diversion +2.
- Priority: btn_sleep, btn_feed and btn_play high in the same cycle in AWAKE → sleeping=1; hambre and diversion unchanged by actions.
- Sleep recovery: enter SLEEP at energia 7 with ENERGY_TICKS=1 → energia 8, then 9 on consecutive ticks; auto-wake sets sleeping=0 at the tick where energia is 9.
- Death: hold hambre at 0 with LIFE_TICKS=1 → vida drops 1 per tick; dead=1 when vida reaches 0; felicidad=0; button pulses leave all stats unchanged.
- Reset mid-operation: assert reset for 1 cycle while in SLEEP with a pending step event → next cycle all stats 9, sleeping=0, dead=0, tick=0.

Source files
------------

// File: rtl/pet_stats_engine.sv
// Pet status engine: owns the five 0..9 levels, decays them on a prescaled game tick,
// applies button actions and tracks the awake/sleep/dead mode.
module pet_stats_engine #(
   parameter int TICK_DIV     = 50_000_000,
   parameter int HUNGER_TICKS = 4,
   parameter int FUN_TICKS    = 3,
   parameter int ENERGY_TICKS = 5,
   parameter int LIFE_TICKS   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_feed,
   input  logic       btn_play,
   input  logic       btn_sleep,
   output logic [3:0] hambre,
   output logic [3:0] diversion,
   output logic [3:0] energia,
   output logic [3:0] felicidad,
   output logic [3:0] vida,
   output logic       sleeping,
   output logic       dead,
   output logic       tick
);
   // state  | meaning
   // AWAKE  | actions accepted, all stats decay
   // SLEEP  | actions ignored, energia recovers, hambre still decays
   // DEAD   | stats frozen, felicidad forced to 0, left only by reset
   typedef enum logic [1:0] {ST_AWAKE, ST_SLEEP, ST_DEAD} state_t;

   localparam int PW = (TICK_DIV     > 1) ? $clog2(TICK_DIV)     : 1;
   localparam int HW = (HUNGER_TICKS > 1) ? $clog2(HUNGER_TICKS) : 1;
   localparam int FW = (FUN_TICKS    > 1) ? $clog2(FUN_TICKS)    : 1;
   localparam int EW = (ENERGY_TICKS > 1) ? $clog2(ENERGY_TICKS) : 1;
   localparam int LW = (LIFE_TICKS   > 1) ? $clog2(LIFE_TICKS)   : 1;

   state_t        state;
   logic [PW-1:0] pre_cnt, pre_nxt;
   logic [HW-1:0] h_cnt;
   logic [FW-1:0] f_cnt;
   logic [EW-1:0] e_cnt;
   logic [LW-1:0] l_cnt;
   logic          h_step, f_step, e_step, l_step;
   logic          awake, asleep, act_feed, act_play;
   logic signed [4:0] h_sum, d_sum, e_sum, v_sum;
   logic [3:0]    h_nxt, d_nxt, e_nxt, v_nxt;
   logic          go_dead;

   function automatic logic [3:0] sat9(input logic signed [4:0] v);
      if (v < 0)
         return 4'd0;
      else if (v > 5'sd9)
         return 4'd9;
      else
         return v[3:0];
   endfunction

   always_comb begin
      pre_nxt  = (pre_cnt == PW'(TICK_DIV - 1)) ? '0 : pre_cnt + 1'b1;
      h_step   = tick && (h_cnt == HW'(HUNGER_TICKS - 1));
      f_step   = tick && (f_cnt == FW'(FUN_TICKS - 1));
      e_step   = tick && (e_cnt == EW'(ENERGY_TICKS - 1));
      l_step   = tick && (l_cnt == LW'(LIFE_TICKS - 1));
      awake    = (state == ST_AWAKE);
      asleep   = (state == ST_SLEEP);
      act_feed = awake && !btn_sleep && btn_feed;
      act_play = awake && !btn_sleep && !btn_feed && btn_play;

      h_sum = $signed({1'b0, hambre}) + (act_feed ? 5'sd3 : 5'sd0)
            - ((h_step && (awake || asleep)) ? 5'sd1 : 5'sd0);
      d_sum = $signed({1'b0, diversion}) + (act_play ? 5'sd2 : 5'sd0)
            - ((f_step && awake) ? 5'sd1 : 5'sd0);
      e_sum = $signed({1'b0, energia}) - (act_play ? 5'sd1 : 5'sd0)
            + ((e_step && asleep) ? 5'sd1 : 5'sd0)
            - ((e_step && awake) ? 5'sd1 : 5'sd0);

      // vida judges the levels as registered this cycle, not the ones being written
      v_sum = $signed({1'b0, vida});
      if (l_step && (awake || asleep)) begin
         if (hambre == 4'd0 || energia == 4'd0)
            v_sum = v_sum - 5'sd1;
         else if (hambre >= 4'd5 && energia >= 4'd5)
            v_sum = v_sum + 5'sd1;
      end

      h_nxt   = sat9(h_sum);
      d_nxt   = sat9(d_sum);
      e_nxt   = sat9(e_sum);
      v_nxt   = sat9(v_sum);
      go_dead = (state == ST_DEAD) || (v_nxt == 4'd0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt   <= '0;
         tick      <= 1'b0;
         h_cnt     <= '0;
         f_cnt     <= '0;
         e_cnt     <= '0;
         l_cnt     <= '0;
         hambre    <= 4'd9;
         diversion <= 4'd9;
         energia   <= 4'd9;
         felicidad <= 4'd9;
         vida      <= 4'd9;
         state     <= ST_AWAKE;
         sleeping  <= 1'b0;
         dead      <= 1'b0;
      end else begin
         pre_cnt <= pre_nxt;
         tick    <= (pre_nxt == PW'(TICK_DIV - 1));
         if (tick) begin
            h_cnt <= h_step ? '0 : h_cnt + 1'b1;
            f_cnt <= f_step ? '0 : f_cnt + 1'b1;
            e_cnt <= e_step ? '0 : e_cnt + 1'b1;
            l_cnt <= l_step ? '0 : l_cnt + 1'b1;
         end

         if (state != ST_DEAD) begin
            hambre    <= h_nxt;
            diversion <= d_nxt;
            energia   <= e_nxt;
            vida      <= v_nxt;
         end
         felicidad <= go_dead ? 4'd0 : 4'((hambre + diversion + 5'd0) >> 1);

         case (state)
            ST_AWAKE: begin
               if (go_dead) begin
                  state <= ST_DEAD;  sleeping <= 1'b0; dead <= 1'b1;
               end else if (btn_sleep) begin
                  state <= ST_SLEEP; sleeping <= 1'b1; dead <= 1'b0;
               end
            end
            ST_SLEEP: begin
               if (go_dead) begin
                  state <= ST_DEAD;  sleeping <= 1'b0; dead <= 1'b1;
               end else if (btn_sleep || (tick && energia == 4'd9)) begin
                  state <= ST_AWAKE; sleeping <= 1'b0; dead <= 1'b0;
               end
            end
            default: begin
               state <= ST_DEAD; sleeping <= 1'b0; dead <= 1'b1;
            end
         endcase
      end
   end
endmodule
